// File: rtl/srl_bus_if.sv
// Bus bundle for the srl_bus delay line: enable, delay select, input and delayed output.
// The master drives stimulus; the slave (the delay line) produces the tapped output.
interface srl_bus_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_DEPTH = 16
);
  localparam int unsigned DLY_W = $clog2(MAX_DEPTH + 1);

  logic             ce;
  logic [DLY_W-1:0] delay;
  logic [WIDTH-1:0] in_data;
  logic             in_vld;
  logic [WIDTH-1:0] out_data;
  logic             out_vld;
  logic             primed;

  modport master (
    output ce, delay, in_data, in_vld,
    input  out_data, out_vld, primed
  );

  modport slave (
    input  ce, delay, in_data, in_vld,
    output out_data, out_vld, primed
  );
endinterface

// File: rtl/srl_bus.sv
// Run-time selectable delay line for a data bus plus valid, advancing on clock enable.
// A saturating fill counter flags when the selected tap holds post-reset history.
module srl_bus #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_DEPTH = 16,
  parameter bit          RST_DATA  = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  srl_bus_if.slave bus
);
  localparam int unsigned     DLY_W  = $clog2(MAX_DEPTH + 1);
  localparam logic [DLY_W-1:0] MaxDly = DLY_W'(MAX_DEPTH);

  logic [WIDTH-1:0]     data_q [MAX_DEPTH];
  logic [WIDTH-1:0]     data_d [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] vld_q, vld_d;
  logic [DLY_W-1:0]     fc_q, fc_d;
  logic [DLY_W-1:0]     dly_eff;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    fc_d   = fc_q;
    if (bus.ce) begin
      data_d[0] = bus.in_data;
      for (int i = 1; i < MAX_DEPTH; i++) begin
        data_d[i] = data_q[i-1];
      end
      vld_d = {vld_q[MAX_DEPTH-2:0], bus.in_vld};
      if (fc_q != MaxDly) begin
        fc_d = fc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      fc_q  <= '0;
    end else begin
      vld_q <= vld_d;
      fc_q  <= fc_d;
    end
  end

  // Leaving data out of reset lets the data stages map onto shift-register primitives.
  if (RST_DATA) begin : g_rst_data
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < MAX_DEPTH; i++) begin
          data_q[i] <= '0;
        end
      end else begin
        data_q <= data_d;
      end
    end
  end else begin : g_no_rst_data
    always_ff @(posedge clk) begin
      data_q <= data_d;
    end
  end

  // Delay 0 is a combinational bypass; larger selects saturate at the last stage.
  always_comb begin
    dly_eff      = (bus.delay > MaxDly) ? MaxDly : bus.delay;
    bus.out_data = bus.in_data;
    bus.out_vld  = bus.in_vld;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (dly_eff == DLY_W'(i + 1)) begin
        bus.out_data = data_q[i];
        bus.out_vld  = vld_q[i];
      end
    end
    bus.primed = (fc_q >= dly_eff);
  end
endmodule
